// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code parser, US-layout ASCII translator and event FIFO.
// Feeds the memory-mapped keyboard register.
module ps2_scancode_decoder #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               scanCode,
  input  logic                     scanCodeReady,
  input  logic                     evtRead,
  output logic                     evtValid,
  output logic [7:0]               evtData,
  output logic [$clog2(DEPTH):0]   evtCount,
  output logic                     overflow,
  output logic                     capsLock,
  output logic                     shiftHeld,
  output logic                     ctrlHeld
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, EXT, BRK, EBRK, SKIP
  } state_t;

  state_t     state, nstate;
  logic [2:0] skip, nskip;
  logic       mk, bk, ext;
  logic       lshift, rshift, lctrl, rctrl, caps_held;
  logic [7:0] lc, dg, sy, sp, tr_ch;
  logic       tr_hit, emit;
  logic       pend_v;
  logic [7:0] pend_d;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, push_ok;

  assign shiftHeld = lshift | rshift;
  assign ctrlHeld  = lctrl | rctrl;

  always_comb begin
    nstate = state;
    nskip  = skip;
    mk     = 1'b0;
    bk     = 1'b0;
    ext    = 1'b0;
    unique case (state)
      IDLE: begin
        if (scanCode == 8'hE0) nstate = EXT;
        else if (scanCode == 8'hF0) nstate = BRK;
        else if (scanCode == 8'hE1) begin
          nstate = SKIP;
          nskip  = 3'd7;
        end else if (scanCode != 8'hAA && scanCode != 8'hFA) mk = 1'b1;
      end
      EXT: begin
        if (scanCode == 8'hF0) nstate = EBRK;
        else begin
          mk     = 1'b1;
          ext    = 1'b1;
          nstate = IDLE;
        end
      end
      BRK: begin
        bk     = 1'b1;
        nstate = IDLE;
      end
      EBRK: begin
        bk     = 1'b1;
        ext    = 1'b1;
        nstate = IDLE;
      end
      SKIP: begin
        nskip = skip - 3'd1;
        if (skip == 3'd1) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    case (scanCode)
      8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";
      8'h23: lc = "d";  8'h24: lc = "e";  8'h2B: lc = "f";
      8'h34: lc = "g";  8'h33: lc = "h";  8'h43: lc = "i";
      8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
      8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";
      8'h4D: lc = "p";  8'h15: lc = "q";  8'h2D: lc = "r";
      8'h1B: lc = "s";  8'h2C: lc = "t";  8'h3C: lc = "u";
      8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
      8'h35: lc = "y";  8'h1A: lc = "z";
      default: lc = 8'h00;
    endcase
  end

  always_comb begin
    case (scanCode)
      8'h45: begin dg = "0"; sy = ")"; end
      8'h16: begin dg = "1"; sy = "!"; end
      8'h1E: begin dg = "2"; sy = "@"; end
      8'h26: begin dg = "3"; sy = "#"; end
      8'h25: begin dg = "4"; sy = "$"; end
      8'h2E: begin dg = "5"; sy = "%"; end
      8'h36: begin dg = "6"; sy = "^"; end
      8'h3D: begin dg = "7"; sy = "&"; end
      8'h3E: begin dg = "8"; sy = "*"; end
      8'h46: begin dg = "9"; sy = "("; end
      default: begin dg = 8'h00; sy = 8'h00; end
    endcase
  end

  always_comb begin
    case (scanCode)
      8'h29:   sp = 8'h20;
      8'h5A:   sp = 8'h0D;
      8'h66:   sp = 8'h08;
      8'h0D:   sp = 8'h09;
      8'h76:   sp = 8'h1B;
      default: sp = 8'h00;
    endcase
  end

  // Modifier flags here are the pre-byte state, as translation requires
  always_comb begin
    tr_hit = 1'b0;
    tr_ch  = 8'h00;
    if (lc != 8'h00) begin
      tr_hit = 1'b1;
      if (ctrlHeld) tr_ch = lc & 8'h1F;
      else if (shiftHeld ^ capsLock) tr_ch = lc - 8'h20;
      else tr_ch = lc;
    end else if (dg != 8'h00) begin
      tr_hit = 1'b1;
      tr_ch  = shiftHeld ? sy : dg;
    end else if (sp != 8'h00) begin
      tr_hit = 1'b1;
      tr_ch  = sp;
    end
  end

  assign emit = mk & tr_hit & (~ext | (scanCode == 8'h5A));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      skip      <= 3'd0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
      capsLock  <= 1'b0;
      caps_held <= 1'b0;
      pend_v    <= 1'b0;
      pend_d    <= 8'h00;
    end else begin
      pend_v <= scanCodeReady & emit;
      pend_d <= tr_ch;
      if (scanCodeReady) begin
        state <= nstate;
        skip  <= nskip;
        if ((mk | bk) & ~ext & (scanCode == 8'h12)) lshift <= mk;
        if ((mk | bk) & ~ext & (scanCode == 8'h59)) rshift <= mk;
        if ((mk | bk) & (scanCode == 8'h14)) begin
          if (ext) rctrl <= mk;
          else lctrl <= mk;
        end
        if (mk & (scanCode == 8'h58)) begin
          if (!caps_held) capsLock <= ~capsLock;
          caps_held <= 1'b1;
        end
        if (bk & (scanCode == 8'h58)) caps_held <= 1'b0;
      end
    end
  end

  assign full    = (count == CW'(DEPTH));
  assign pop     = evtRead & (count != '0);
  assign push_ok = pend_v & (~full | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (pend_v & ~push_ok) overflow <= 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= pend_d;
  end

  assign evtValid = (count != '0);
  assign evtData  = evtValid ? mem[rd_ptr] : 8'h00;
  assign evtCount = count;

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the set-2 scan-code byte stream from the PS/2 keyboard receiver (`scanCode` / `scanCodeReady`) and turns it into ASCII characters for the CPU.
- Tracks the prefix bytes (E0, F0, E1) and the modifier state (shift, ctrl, caps lock).
- Translates make codes to US-layout ASCII.
- Buffers the characters in a small FIFO, which the CPU drains through a valid/read handshake.

It sits between the PS/2 receiver and the memory-mapped keyboard register.

## Interface
- `DEPTH`, default 8: FIFO entries. Must be a power of two and at least 2.
- `clk`  in  1  system clock (same clock as the receiver)
- `rst`  in  1  reset, asynchronous, active-low
- `scanCode`  in  8  byte from the receiver; valid only while `scanCodeReady`=1
- `scanCodeReady`  in  1  one-cycle pulse per received byte
- `evtRead`  in  1  pops the head entry when `evtValid`=1; ignored when the FIFO is empty
- `evtValid`  out  1  FIFO is non-empty
- `evtData`  out  8  ASCII character at the FIFO head; 0x00 when empty
- `evtCount`  out  $clog2(DEPTH)+1  number of entries in the FIFO
- `overflow`  out  1  sticky; set when a character is dropped because the FIFO is full
- `capsLock`  out  1  caps-lock toggle state
- `shiftHeld`  out  1  left or right shift is held
- `ctrlHeld`  out  1  left or right ctrl is held

## Operation
- Reset value of every output is 0. Reset also clears the FIFO, the pointers, all modifier and held flags, and the parser state (IDLE). Reset may occur at any point, including mid-sequence or mid-pop.
- Parser FSM. Each `scanCodeReady` cycle is one byte.
  - IDLE, byte E0 → EXT.
  - IDLE, byte F0 → BRK.
  - IDLE, byte E1 → SKIP with skip counter = 7. This drops the rest of the Pause sequence.
  - IDLE, any other byte → make(byte, ext=0).
  - EXT, byte F0 → EBRK.
  - EXT, any other byte → make(byte, ext=1), then IDLE.
  - BRK, any byte → break(byte, ext=0), then IDLE.
  - EBRK, any byte → break(byte, ext=1), then IDLE.
  - SKIP: decrement the counter on every byte; go to IDLE after the byte that brings it to 0.
  - Byte AA (BAT pass) and byte FA (ack) in IDLE are dropped; the FSM stays in IDLE.
- Modifiers:
  - 12/59 set the lshift/rshift held flags on make and clear them on break. This applies only when ext=0; E0 12 is ignored.
  - 14 sets lctrl (ext=0) or rctrl (ext=1) on make and clears it on break.
  - 58 make toggles `capsLock` only if capsHeld=0, then sets capsHeld. 58 break clears capsHeld. Typematic repeats therefore do not re-toggle.
- Translation applies to a make with ext=0, plus the one extended key E0 5A.
  - Letters: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
    - Uppercase when shiftHeld XOR capsLock, otherwise lowercase.
    - When ctrlHeld, the result is uppercase & 0x1F, regardless of shift.
  - Digits: 45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9. With shift they give ) ! @ # $ % ^ & * ( respectively.
  - Specials, unaffected by modifiers: 29 → 0x20, 5A/E0 5A → 0x0D, 66 → 0x08, 0D → 0x09, 76 → 0x1B.
  - All other codes and all breaks produce no character.
  - Typematic repeat makes each produce a character.
- FIFO:
  - A translated character is pushed at the tail; `evtData` shows the head.
  - Full with no pop in the same cycle: the character is dropped and `overflow` is set. `overflow` is cleared only by reset.
  - Push and pop in the same cycle: when non-empty, both happen and the count is unchanged. When empty, the push happens and the pop is ignored.
  - When full, a same-cycle pop frees the slot, so the push succeeds and no overflow occurs.
  - Pointers wrap modulo DEPTH.

## Timing
- Edge T0 is the edge at which `scanCodeReady`=1 is sampled.
  - Parser state and modifier flags update at T0.
  - The translated character is registered at T0.
  - The FIFO write happens at T0+1, so `evtValid`/`evtData`/`evtCount` reflect it after T0+1. Latency is 2 edges.
- Bytes may arrive on consecutive cycles; the pipeline accepts one byte per cycle.
- Translation uses the modifier state that exists before the current byte is applied.
- A pop on edge T updates `evtData`/`evtCount` after T. `evtData` and `evtValid` are registered/derived from registered state and carry no combinational path from inputs.

## Test plan
- Reset, then send 1C → `evtValid`=1 with `evtData`=0x61 two edges after the byte; assert `evtRead` for one cycle → `evtValid`=0, `evtCount`=0.
- Send 12, 1C, F0 1C, F0 12, 1C → the FIFO holds 0x41 then 0x61; `shiftHeld` goes 1→0 on the F0 12 byte.
- Send 58 58 F0 58 (a repeat followed by release), then 1C; then 12 1C → `capsLock`=1, characters are 0x41 then 0x61 (shift XOR caps); send 58 again → `capsLock`=0.
- Send E0 14 (right ctrl), 21 → 0x03, `ctrlHeld`=1; send E0 F0 14 → `ctrlHeld`=0. Send E1 14 77 E1 F0 14 F0 77, then 16 → exactly one entry, 0x31. Send E0 5A → 0x0D.
- With DEPTH=8 and no reads, send 9 makes of 29 → `evtCount`=8, `overflow`=1, all entries 0x20. Then hold `evtRead` while sending 1C → count stays 8 with a 0x61 entry at the tail. Drain all 8 → order preserved, pointer wrap correct.
- Assert `rst` low mid-sequence after E0 F0 with 3 entries queued → all outputs 0 immediately; after release, byte 14 is treated as an IDLE make (`ctrlHeld`=1) and produces no character.
